card_dealer: RTL and testbench
==============================

# card_dealer

Upstream deal stage for `hand_comparator`. On a `deal` request it draws nine distinct cards from a 52-card deck using a free-running 16-bit LFSR with rejection sampling and a used-card bitmap. It presents the cards on `player1`, `player2` and `community` in the `card_t` format from `poker_types.svh`. It then pulses `cmp_start`, which drives the comparator's `start` input.

## Interface
- `SEED`, 16'hACE1, LFSR value at reset; also substituted for a loaded seed of 0.
- `REJECT_LIMIT`, 63, consecutive rejections tolerated before the fallback draw is used. A value of 0 makes every draw use the fallback.
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `deal`  in  1  request a new hand; sampled only in IDLE.
- `seed_valid`  in  1  load `seed` into the LFSR; sampled only in IDLE.
- `seed`  in  16  LFSR seed value.
- `player1`  out  card_t[2]  player 1 hole cards.
- `player2`  out  card_t[2]  player 2 hole cards.
- `community`  out  card_t[5]  board cards.
- `busy`  out  1  high while dealing (DRAW and DONE).
- `cmp_start`  out  1  one-cycle pulse when a complete hand is presented.
- `deal_done`  out  1  one-cycle pulse, coincident with `cmp_start`.

## Operation
- **Card index 0..51** maps to a card as follows:
  - rank = ordinal (idx % 13) of `rank_t`, where Two = 0 and Ace = 12.
  - suit = ordinal (idx / 13) of `suit_t`, in the order Hearts, Diamonds, Clubs, Spades.
- **LFSR:** 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1).
  - It advances every cycle in every state.
  - In IDLE, `seed_valid` overrides the advance: lfsr <= (seed == 0) ? SEED : seed.
- **Candidate:** cand = lfsr[5:0].
  - A candidate is rejected if cand ≥ 52 or used[cand] = 1.
  - fallback = lowest index with used = 0, found by a priority encoder.
- **State machine:**
  - IDLE:
    - `deal` → DRAW. Clear slot counter, reject counter and used bitmap.
    - `deal` and `seed_valid` in the same cycle: the seed loads, DRAW is entered, and the first candidate is taken from the loaded seed.
  - DRAW: each cycle exactly one of the following happens:
    - Accept cand when not rejected and rej_cnt < REJECT_LIMIT.
    - Accept fallback when rej_cnt ≥ REJECT_LIMIT. Then rej_cnt <= 0.
    - Otherwise reject: rej_cnt saturating-increments.
  - On accept: set used[idx], write the card to shadow slot `slot`, slot++, rej_cnt <= 0.
  - After the 9th accept → DONE.
  - DONE:
    - Copy all shadow slots to the outputs in one edge.
    - `cmp_start` = `deal_done` = 1 for this single cycle.
    - → IDLE.
- **Slot order:** 0 → player1[0], 1 → player2[0], 2 → player1[1], 3 → player2[1], 4..8 → community[0..4].
- **Widths:** slot is 4 bits, range 0..8. rej_cnt is $clog2(REJECT_LIMIT+1) bits and saturates. used is 52 bits.
- **Output stability:** card outputs change only at the DONE edge and hold until the next DONE. The system must not issue `deal` before the comparator's `winner_valid`.

## Timing
- **Reset values:**
  - All card outputs: every field 0.
  - `busy` = `cmp_start` = `deal_done` = 0.
  - state = IDLE, lfsr = SEED, used = 0, slot = 0, rej_cnt = 0.
- **Latency:**
  - `deal` sampled at edge 0 → DRAW visible in cycle 1.
  - Best case: 9 DRAW cycles, then `cmp_start` high in cycle 10, and cards valid in that same cycle.
  - Worst case: 9 × (REJECT_LIMIT+1) DRAW cycles + 1.
- **`busy`:** high from cycle 1 through the DONE cycle inclusive; low again the following cycle.
- **Ignored inputs:** `deal` and `seed_valid` are ignored outside IDLE. They are not queued.
- **Back-to-back:** a `deal` sampled in the cycle right after DONE, with the state back in IDLE, starts a new hand.
- **Reset mid-deal:** `reset` has priority over everything. Outputs return to reset values the next cycle, and any in-flight shadow cards are discarded.

## Test plan
- **Reset values:** assert reset for 2 cycles → all cards 0, `busy` = 0, `cmp_start` = 0, and lfsr = 16'hACE1 (hierarchical check).
- **Deterministic fallback:** REJECT_LIMIT = 0, `deal` pulse →
  - `cmp_start` exactly in cycle 10, one cycle wide.
  - player1 = {Two Hearts, Four Hearts}, player2 = {Three Hearts, Five Hearts}.
  - community = Six..Ten Hearts.
- **Default-parameter deal:** seed 16'h1234, then `deal`.
  - All 9 cards are distinct with index < 52.
  - The hand matches a bench LFSR reference model.
  - `cmp_start` arrives between cycle 10 and cycle 9×64+1.
- **Ignored requests and output stability:**
  - `deal` held high for the whole hand → exactly one `cmp_start`.
  - `seed_valid` during DRAW leaves the hand unchanged versus the model.
  - Outputs are constant from DONE until the next DONE.
- **Repeatability and zero seed:**
  - Load seed 0, deal, then load seed 0 again and deal → identical hands, both equal to a deal seeded with 16'hACE1.
- **Mid-deal reset:** reset in cycle 4 of DRAW → next cycle all outputs are 0 and `busy` = 0. A subsequent `deal` completes with 9 distinct cards.

Source files
------------

// File: rtl/card_dealer_if.sv
// Card type definitions shared by the dealer and the comparator, plus the
// dealer request/hand interface.
package poker_types_pkg;
  typedef enum logic [3:0] {
    TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN, JACK, QUEEN, KING, ACE
  } rank_t;

  typedef enum logic [1:0] {HEARTS, DIAMONDS, CLUBS, SPADES} suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;
endpackage

interface card_dealer_if;
  import poker_types_pkg::*;

  logic        deal;
  logic        seed_valid;
  logic [15:0] seed;
  card_t [1:0] player1;
  card_t [1:0] player2;
  card_t [4:0] community;
  logic        busy;
  logic        cmp_start;
  logic        deal_done;

  modport master (
    output deal, seed_valid, seed,
    input  player1, player2, community, busy, cmp_start, deal_done
  );

  modport slave (
    input  deal, seed_valid, seed,
    output player1, player2, community, busy, cmp_start, deal_done
  );
endinterface

// File: rtl/card_dealer.sv
// Deals nine distinct cards from a 52-card deck using an LFSR with rejection
// sampling, then presents the hand and pulses cmp_start for the comparator.
module card_dealer
  import poker_types_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned REJECT_LIMIT = 63
) (
  input  logic          clk,
  input  logic          reset,
  card_dealer_if.slave  bus
);

  localparam int unsigned NUM_CARDS = 52;
  localparam int unsigned HAND_SIZE = 9;
  localparam int unsigned REJ_W     = (REJECT_LIMIT == 0) ? 1 : $clog2(REJECT_LIMIT + 1);
  localparam logic [REJ_W-1:0] REJ_LIM = REJ_W'(REJECT_LIMIT);
  localparam logic [REJ_W-1:0] REJ_MAX = '1;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [51:0]      used, used_nxt;
  logic [3:0]       slot, slot_nxt;
  logic [REJ_W-1:0] rej_cnt, rej_nxt;
  card_t [8:0]      shadow, shadow_nxt;

  logic [5:0]  cand;
  logic [5:0]  fallback;
  logic [5:0]  pick;
  logic [63:0] used_ext;
  logic        cand_ok;
  logic        accept;

  function automatic card_t idx_to_card(input logic [5:0] idx);
    card_t c;
    c.rank = rank_t'(4'(idx % 6'd13));
    c.suit = suit_t'(2'(idx / 6'd13));
    return c;
  endfunction

  // Out-of-deck candidates (52..63) read as permanently used.
  assign cand     = lfsr[5:0];
  assign used_ext = {12'hFFF, used};
  assign cand_ok  = !used_ext[cand];

  // Lowest free card index.
  always_comb begin
    fallback = '0;
    for (int i = int'(NUM_CARDS) - 1; i >= 0; i--) begin
      if (!used[6'(i)]) fallback = 6'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    used_nxt   = used;
    slot_nxt   = slot;
    rej_nxt    = rej_cnt;
    shadow_nxt = shadow;
    accept     = 1'b0;
    pick       = cand;
    unique case (state)
      IDLE: begin
        if (bus.seed_valid) lfsr_nxt = (bus.seed == 16'h0000) ? SEED : bus.seed;
        if (bus.deal) begin
          state_nxt = DRAW;
          used_nxt  = '0;
          slot_nxt  = '0;
          rej_nxt   = '0;
        end
      end
      DRAW: begin
        if (rej_cnt >= REJ_LIM) begin
          accept = 1'b1;
          pick   = fallback;
        end else if (cand_ok) begin
          accept = 1'b1;
        end else if (rej_cnt != REJ_MAX) begin
          rej_nxt = rej_cnt + 1'b1;
        end
        if (accept) begin
          used_nxt[pick]   = 1'b1;
          shadow_nxt[slot] = idx_to_card(pick);
          slot_nxt         = slot + 4'd1;
          rej_nxt          = '0;
          if (slot == 4'(HAND_SIZE - 1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr    <= SEED;
      used    <= '0;
      slot    <= '0;
      rej_cnt <= '0;
      shadow  <= '0;
    end else begin
      lfsr    <= lfsr_nxt;
      used    <= used_nxt;
      slot    <= slot_nxt;
      rej_cnt <= rej_nxt;
      shadow  <= shadow_nxt;
    end
  end

  // Hand is published on the edge that enters DONE so cards and cmp_start align.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.player1   <= '0;
      bus.player2   <= '0;
      bus.community <= '0;
      bus.busy      <= 1'b0;
      bus.cmp_start <= 1'b0;
      bus.deal_done <= 1'b0;
    end else begin
      bus.busy      <= (state_nxt != IDLE);
      bus.cmp_start <= (state_nxt == DONE);
      bus.deal_done <= (state_nxt == DONE);
      if (state == DRAW && state_nxt == DONE) begin
        bus.player1   <= {shadow_nxt[2], shadow_nxt[0]};
        bus.player2   <= {shadow_nxt[3], shadow_nxt[1]};
        bus.community <= shadow_nxt[8:4];
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: forced-fallback instance with hand-derived cards, and a
// default instance checked against an LFSR reference model.
module tb_card_dealer;
  import poker_types_pkg::*;

  typedef card_t [8:0] hand_t;

  typedef struct {
    logic [15:0] seed;
    bit          hold;
    bit          glitch;
    hand_t       exp_hand;
    int          exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  card_dealer_if bus ();
  card_dealer_if bus0 ();

  card_dealer #(.SEED(16'hACE1), .REJECT_LIMIT(63)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  card_dealer #(.SEED(16'hACE1), .REJECT_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  hand_t last_hand;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic card_t mk(input int x);
    card_t c;
    c.rank = rank_t'(4'(x % 13));
    c.suit = suit_t'(2'(x / 13));
    return c;
  endfunction

  function automatic hand_t cur_hand();
    hand_t h;
    h[0] = bus.player1[0];
    h[1] = bus.player2[0];
    h[2] = bus.player1[1];
    h[3] = bus.player2[1];
    for (int i = 0; i < 5; i++) h[4'(4 + i)] = bus.community[3'(i)];
    return h;
  endfunction

  function automatic bit distinct(input hand_t h);
    logic [51:0] seen;
    int x;
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      if (int'(h[4'(i)].rank) > 12) return 1'b0;
      x = int'(h[4'(i)].suit) * 13 + int'(h[4'(i)].rank);
      if (seen[6'(x)]) return 1'b0;
      seen[6'(x)] = 1'b1;
    end
    return 1'b1;
  endfunction

  // Reference: seed loaded with deal, so the first candidate comes from the seed.
  task automatic model(input logic [15:0] sd, output hand_t h, output int cyc);
    logic [15:0] l;
    logic [51:0] u;
    int rej, n, c, f;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    u = '0; rej = 0; n = 0; cyc = 0; h = '0;
    while (n < 9) begin
      c = int'(l[5:0]);
      cyc++;
      f = -1;
      if (rej >= 63) begin
        for (int i = 51; i >= 0; i--) if (!u[6'(i)]) f = i;
      end else if (c < 52 && !u[6'(c)]) begin
        f = c;
      end
      if (f >= 0) begin
        u[6'(f)] = 1'b1;
        h[4'(n)] = mk(f);
        n++;
        rej = 0;
      end else begin
        rej++;
      end
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    cyc = cyc + 1;
  endtask

  task automatic run_deal(input logic [15:0] sd, input bit ld, input bit hold,
                          input bit glitch, output hand_t h, output int cyc);
    int pulses;
    bit busy_ok, dd_ok, stable_ok;
    pulses = 0; cyc = 0; busy_ok = 1; dd_ok = 1; stable_ok = 1; h = '0;
    @(negedge clk);
    bus.deal = 1'b1; bus.seed_valid = ld; bus.seed = sd;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      bus.deal       = hold && cyc == 0;
      bus.seed_valid = glitch && cyc == 0;
      bus.seed       = glitch ? 16'h5A5A : sd;
      if (bus.deal_done !== bus.cmp_start) dd_ok = 0;
      if (cyc == 0 && bus.busy !== 1'b1) busy_ok = 0;
      if (cyc == 0 && bus.cmp_start !== 1'b1 && cur_hand() !== last_hand) stable_ok = 0;
      if (cyc != 0 && cur_hand() !== h) stable_ok = 0;
      if (cyc != 0 && c == cyc + 1 && bus.busy !== 1'b0) busy_ok = 0;
      if (bus.cmp_start === 1'b1) begin
        pulses++;
        if (cyc == 0) begin
          cyc = c;
          h = cur_hand();
          bus.deal = 1'b0;
          bus.seed_valid = 1'b0;
        end
      end
      if (cyc != 0 && c >= cyc + 4) break;
    end
    bus.deal = 1'b0; bus.seed_valid = 1'b0;
    check("deal_timeout", 64'(cyc != 0), 64'd1);
    check("cmp_start_pulses", 64'(pulses), 64'd1);
    check("busy_window", 64'(busy_ok), 64'd1);
    check("deal_done_align", 64'(dd_ok), 64'd1);
    check("output_stable", 64'(stable_ok), 64'd1);
    if (cyc != 0) last_hand = h;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[6];
    card_t fb_exp[9];
    hand_t fh, h, hands[6];
    int    fcyc, fw, cyc;

    bus.deal = 1'b0; bus.seed_valid = 1'b0; bus.seed = 16'h0;
    bus0.deal = 1'b0; bus0.seed_valid = 1'b0; bus0.seed = 16'h0;
    reset = 1'b1;
    last_hand = '0;

    vecs[0] = '{seed: 16'h1234, hold: 1'b0, glitch: 1'b0, exp_hand: '0, exp_cyc: 0};
    vecs[1] = '{seed: 16'h1234, hold: 1'b1, glitch: 1'b0, exp_hand: '0, exp_cyc: 0};
    vecs[2] = '{seed: 16'h1234, hold: 1'b0, glitch: 1'b1, exp_hand: '0, exp_cyc: 0};
    vecs[3] = '{seed: 16'h0000, hold: 1'b0, glitch: 1'b0, exp_hand: '0, exp_cyc: 0};
    vecs[4] = '{seed: 16'h0000, hold: 1'b0, glitch: 1'b0, exp_hand: '0, exp_cyc: 0};
    vecs[5] = '{seed: 16'hACE1, hold: 1'b0, glitch: 1'b0, exp_hand: '0, exp_cyc: 0};
    for (int i = 0; i < 6; i++) model(vecs[i].seed, vecs[i].exp_hand, vecs[i].exp_cyc);

    // Forced fallback deals the lowest indices 0..8 in slot order.
    fb_exp = '{'{TWO, HEARTS}, '{THREE, HEARTS}, '{FOUR, HEARTS}, '{FIVE, HEARTS},
               '{SIX, HEARTS}, '{SEVEN, HEARTS}, '{EIGHT, HEARTS}, '{NINE, HEARTS},
               '{TEN, HEARTS}};

    repeat (2) @(negedge clk);
    check("rst_cards", 64'(cur_hand()), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cmp_start", 64'(bus.cmp_start), 64'd0);
    check("rst_deal_done", 64'(bus.deal_done), 64'd0);
    check("rst_lfsr", 64'(dut.lfsr), 64'hACE1);
    check("rst_fb_cards", 64'({bus0.player1, bus0.player2, bus0.community}), 64'd0);
    reset = 1'b0;

    @(negedge clk);
    bus0.deal = 1'b1;
    fcyc = 0; fw = 0; fh = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus0.deal = 1'b0;
      if (bus0.cmp_start === 1'b1) begin
        fw++;
        if (fcyc == 0) begin
          fcyc = c;
          fh[0] = bus0.player1[0];
          fh[1] = bus0.player2[0];
          fh[2] = bus0.player1[1];
          fh[3] = bus0.player2[1];
          for (int k = 0; k < 5; k++) fh[4'(4 + k)] = bus0.community[3'(k)];
        end
      end
      if (fcyc != 0 && c >= fcyc + 3) break;
    end
    check("fb_cmp_start_cycle", 64'(fcyc), 64'd10);
    check("fb_cmp_start_width", 64'(fw), 64'd1);
    for (int i = 0; i < 9; i++)
      check($sformatf("fb_slot%0d", i), 64'(fh[4'(i)]), 64'(fb_exp[i]));

    for (int i = 0; i < 6; i++) begin
      run_deal(vecs[i].seed, 1'b1, vecs[i].hold, vecs[i].glitch, h, cyc);
      hands[i] = h;
      check($sformatf("v%0d_hand", i), 64'(h), 64'(vecs[i].exp_hand));
      check($sformatf("v%0d_cycle", i), 64'(cyc), 64'(vecs[i].exp_cyc));
      check($sformatf("v%0d_distinct", i), 64'(distinct(h)), 64'd1);
      check($sformatf("v%0d_latency_range", i), 64'(cyc >= 10 && cyc <= 9 * 64 + 1), 64'd1);
    end

    // First two ACE1 candidates 33 and 48 both accepted: Nine of Clubs, Jack of Spades.
    check("ace1_p1_0", 64'(hands[5][0]), 64'(card_t'{NINE, CLUBS}));
    check("ace1_p2_0", 64'(hands[5][1]), 64'(card_t'{JACK, SPADES}));
    check("seed0_p1_0", 64'(hands[3][0]), 64'(card_t'{NINE, CLUBS}));
    check("seed0_repeat", 64'(hands[4]), 64'(hands[3]));

    @(negedge clk);
    bus.deal = 1'b1;
    @(negedge clk);
    bus.deal = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cards", 64'(cur_hand()), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_cmp_start", 64'(bus.cmp_start), 64'd0);
    check("mid_rst_lfsr", 64'(dut.lfsr), 64'hACE1);
    reset = 1'b0;
    last_hand = '0;
    run_deal(16'h0000, 1'b0, 1'b0, 1'b0, h, cyc);
    check("post_rst_distinct", 64'(distinct(h)), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
